// File: rtl/reg_dump_pkg.sv
// Shared types, constants and the nibble-to-ASCII helper for the register dump UART.
// Optional build macro: REG_DUMP_ASCII_EN selects the 13-byte ASCII line format.
package reg_dump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_LATCH  = 3'd2,
      ST_SEND   = 3'd3,
      ST_NEXT   = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   localparam int NUM_REGS = 32;
`ifdef REG_DUMP_ASCII_EN
   localparam int BYTES_PER_REG = 13;
`else
   localparam int BYTES_PER_REG = 5;
`endif
   localparam logic UART_IDLE = 1'b1;

   // Uppercase hex digit: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         hex_ascii = 8'h30 + {4'h0, nib};
      end else begin
         hex_ascii = 8'h37 + {4'h0, nib};
      end
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter; ready rises in the last stop-bit cycle so a byte
// offered then starts its start bit immediately after, keeping frames back-to-back.
module uart_tx_byte
   import reg_dump_pkg::*;
#(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   logic        active_r;
   logic [8:0]  shift_r;
   logic [3:0]  bit_cnt_r;
   logic [15:0] baud_cnt_r;
   logic        tx_r;
   logic        last_s;

   assign last_s = active_r && (bit_cnt_r == 4'd9) && (baud_cnt_r == BAUD_LAST);
   assign ready  = !active_r || last_s;
   assign tx     = tx_r;

   // Frame sequencer: bit 0 is the start bit, 1-8 data LSB first, 9 the stop bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_r   <= 1'b0;
         shift_r    <= 9'h1FF;
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= 16'd0;
         tx_r       <= UART_IDLE;
      end else if (valid && ready) begin
         active_r   <= 1'b1;
         shift_r    <= {1'b1, data};
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= 16'd0;
         tx_r       <= 1'b0;
      end else if (active_r) begin
         if (baud_cnt_r == BAUD_LAST) begin
            baud_cnt_r <= 16'd0;
            if (bit_cnt_r == 4'd9) begin
               active_r <= 1'b0;
               tx_r     <= UART_IDLE;
            end else begin
               bit_cnt_r <= bit_cnt_r + 4'd1;
               tx_r      <= shift_r[0];
               shift_r   <= {1'b1, shift_r[8:1]};
            end
         end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
         end
      end
   end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Sweeps all 32 CPU registers through the register read port and streams them over UART.
// Build macro REG_DUMP_ASCII_EN switches from 5-byte binary records to ASCII hex lines.
module reg_dump_uart_tx
   import reg_dump_pkg::*;
#(
   parameter int BAUD_DIV      = 434,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] regData,
   output logic [4:0]  regAddress,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] LAST_BYTE   = 4'(BYTES_PER_REG - 1);
   localparam logic [4:0] LAST_REG    = 5'(NUM_REGS - 1);

   state_t      state_r, next_state_s;
   logic [7:0]  settle_cnt_r, next_settle_cnt_s;
   logic [3:0]  byte_idx_r, next_byte_idx_s;
   logic [31:0] data_buf_r, next_data_buf_s;
   logic [4:0]  addr_r, next_addr_s;
   logic        busy_r, next_busy_s;
   logic        done_r, next_done_s;
   logic [7:0]  byte_s;
   logic        valid_s;
   logic        ready_s;

   assign regAddress = addr_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign valid_s    = (state_r == ST_SEND);

   // Byte selector for the current position within a register record
   always_comb begin
      byte_s = 8'h00;
`ifdef REG_DUMP_ASCII_EN
      case (byte_idx_r)
         4'd0:    byte_s = hex_ascii({3'b000, addr_r[4]});
         4'd1:    byte_s = hex_ascii(addr_r[3:0]);
         4'd2:    byte_s = 8'h20;
         4'd3:    byte_s = hex_ascii(data_buf_r[31:28]);
         4'd4:    byte_s = hex_ascii(data_buf_r[27:24]);
         4'd5:    byte_s = hex_ascii(data_buf_r[23:20]);
         4'd6:    byte_s = hex_ascii(data_buf_r[19:16]);
         4'd7:    byte_s = hex_ascii(data_buf_r[15:12]);
         4'd8:    byte_s = hex_ascii(data_buf_r[11:8]);
         4'd9:    byte_s = hex_ascii(data_buf_r[7:4]);
         4'd10:   byte_s = hex_ascii(data_buf_r[3:0]);
         4'd11:   byte_s = 8'h0D;
         4'd12:   byte_s = 8'h0A;
         default: byte_s = 8'h00;
      endcase
`else
      case (byte_idx_r)
         4'd0:    byte_s = {3'b000, addr_r};
         4'd1:    byte_s = data_buf_r[31:24];
         4'd2:    byte_s = data_buf_r[23:16];
         4'd3:    byte_s = data_buf_r[15:8];
         4'd4:    byte_s = data_buf_r[7:0];
         default: byte_s = 8'h00;
      endcase
`endif
   end

   uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk   (clk),
      .rst   (rst),
      .data  (byte_s),
      .valid (valid_s),
      .ready (ready_s),
      .tx    (tx)
   );

   // Sweep sequencer next-state logic
   always_comb begin
      next_state_s      = state_r;
      next_settle_cnt_s = settle_cnt_r;
      next_byte_idx_s   = byte_idx_r;
      next_data_buf_s   = data_buf_r;
      next_addr_s       = addr_r;
      next_busy_s       = busy_r;
      next_done_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_addr_s       = 5'd0;
               next_settle_cnt_s = 8'd0;
               next_busy_s       = 1'b1;
               next_state_s      = ST_SETTLE;
            end else begin
               next_busy_s = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_r == SETTLE_LAST) begin
               next_settle_cnt_s = 8'd0;
               next_state_s      = ST_LATCH;
            end else begin
               next_settle_cnt_s = settle_cnt_r + 8'd1;
            end
         end
         ST_LATCH: begin
            next_data_buf_s = regData;
            next_byte_idx_s = 4'd0;
            next_state_s    = ST_SEND;
         end
         ST_SEND: begin
            if (ready_s) begin
               if (byte_idx_r == LAST_BYTE) begin
                  next_state_s = ST_NEXT;
               end else begin
                  next_byte_idx_s = byte_idx_r + 4'd1;
               end
            end else begin
               next_state_s = ST_SEND;
            end
         end
         ST_NEXT: begin
            if (addr_r == LAST_REG) begin
               next_state_s = ST_FINISH;
            end else begin
               next_addr_s  = addr_r + 5'd1;
               next_state_s = ST_SETTLE;
            end
         end
         ST_FINISH: begin
            // ready here means the final stop bit is in its last cycle
            if (ready_s) begin
               next_done_s  = 1'b1;
               next_busy_s  = 1'b0;
               next_addr_s  = 5'd0;
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_FINISH;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
            next_busy_s  = 1'b0;
         end
      endcase
   end

   // Sweep sequencer state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         settle_cnt_r <= 8'd0;
         byte_idx_r   <= 4'd0;
         data_buf_r   <= 32'd0;
         addr_r       <= 5'd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         settle_cnt_r <= next_settle_cnt_s;
         byte_idx_r   <= next_byte_idx_s;
         data_buf_r   <= next_data_buf_s;
         addr_r       <= next_addr_s;
         busy_r       <= next_busy_s;
         done_r       <= next_done_s;
      end
   end

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Scoreboard bench for reg_dump_uart_tx: a UART receiver decodes tx and checks
// each byte against the queue filled when a sweep is started (REG_DUMP_ASCII_EN aware).
module tb_reg_dump_uart_tx;

   localparam int BAUD   = 4;
   localparam int SETTLE = 2;
`ifdef REG_DUMP_ASCII_EN
   localparam int BPR        = 13;
   localparam int FIRST_LOW  = 20;
   localparam int FIRST_HIGH = 8;
`else
   localparam int BPR        = 5;
   localparam int FIRST_LOW  = 36;
   localparam int FIRST_HIGH = 4;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] regData;
   logic [4:0]  regAddress;
   logic        tx, busy, done;
   logic [31:0] regs [32];

   int         compared = 0;
   int         mismatched = 0;
   int         rx_bytes = 0;
   int         done_cnt = 0;
   logic       rx_en = 1'b0;
   logic [7:0] exp_q [$];

   assign regData = regs[regAddress];

   always #5 clk = ~clk;

   reg_dump_uart_tx #(.BAUD_DIV(BAUD), .SETTLE_CYCLES(SETTLE)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .regData    (regData),
      .regAddress (regAddress),
      .tx         (tx),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] hx(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   task automatic push_sweep();
      for (int r = 0; r < 32; r++) begin
         logic [4:0]  a;
         logic [31:0] v;
         a = 5'(r);
         v = regs[r];
`ifdef REG_DUMP_ASCII_EN
         exp_q.push_back(hx({3'b000, a[4]}));
         exp_q.push_back(hx(a[3:0]));
         exp_q.push_back(8'h20);
         for (int k = 7; k >= 0; k--) exp_q.push_back(hx(v[4*k +: 4]));
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
`else
         exp_q.push_back({3'b000, a});
         exp_q.push_back(v[31:24]);
         exp_q.push_back(v[23:16]);
         exp_q.push_back(v[15:8]);
         exp_q.push_back(v[7:0]);
`endif
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 25000) begin
         @(negedge clk);
         n++;
      end
      check(name, done_cnt - d0, 1);
   endtask

   // UART receiver / scoreboard monitor, sampling at mid-bit on negedges
   initial begin
      logic [7:0] b;
      logic       stop;
      forever begin
         @(negedge clk);
         if (rx_en && rst && tx === 1'b0) begin
            repeat (BAUD / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (BAUD) @(negedge clk);
               b[k] = tx;
            end
            repeat (BAUD) @(negedge clk);
            stop = tx;
            check("stop_bit", stop, 1);
            rx_bytes++;
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_byte: got %0h, expected none", b);
            end else begin
               check("rx_byte", b, exp_q.pop_front());
            end
            repeat (BAUD / 2 - 1) @(negedge clk);
         end
      end
   end

   // done pulse monitor
   always @(negedge clk) begin
      if (rst && done === 1'b1) begin
         done_cnt++;
         check("busy_at_done", busy, 0);
         check("addr_at_done", regAddress, 0);
         check("queue_empty_at_done", exp_q.size(), 0);
      end
   end

   initial begin
      int bad, n, lo, hi, base, d0;
      for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h01010101;
      regs[0]  = 32'hA500_0000;
      regs[5]  = 32'hDEAD_BEEF;
      regs[10] = 32'h0000_12AB;
      regs[31] = 32'h0000_0001;

      // reset idle
      repeat (3) @(negedge clk);
      rst = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || regAddress !== 5'd0) bad++;
      end
      check("reset_idle", bad, 0);

      // sweep 1: content and first-frame timing
      rx_en = 1'b1;
      base = rx_bytes;
      d0 = done_cnt;
      push_sweep();
      @(negedge clk);
      start = 1'b1;
      check("busy_before_accept", busy, 0);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", busy, 1);
      n = 0;
      while (tx !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      lo = 0;
      while (tx === 1'b0 && lo < 100) begin
         @(negedge clk);
         lo++;
      end
      hi = 0;
      while (tx === 1'b1 && hi < 100) begin
         @(negedge clk);
         hi++;
      end
      check("first_frame_low", lo, FIRST_LOW);
      check("first_frame_high", hi, FIRST_HIGH);
      wait_done(d0, "sweep1_done");
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("sweep1_bytes", rx_bytes - base, 32 * BPR);

      // sweep 2: start re-pulsed while busy is ignored
      base = rx_bytes;
      d0 = done_cnt;
      push_sweep();
      pulse_start();
      n = 0;
      while (regAddress !== 5'd10 && n < 25000) begin
         @(negedge clk);
         n++;
      end
      check("reached_reg10", regAddress, 10);
      pulse_start();
      wait_done(d0, "sweep2_done");
      repeat (200) @(negedge clk);
      check("sweep2_single_done", done_cnt - d0, 1);
      check("sweep2_bytes", rx_bytes - base, 32 * BPR);
      check("sweep2_no_restart", busy, 0);

      // sweep 3: asynchronous reset in a data bit of the first frame
      rx_en = 1'b0;
      pulse_start();
      repeat (20) @(negedge clk);
      check("busy_before_reset", busy, 1);
      rst = 1'b0;
      #1;
      check("reset_tx_async", tx, 1);
      check("reset_busy_async", busy, 0);
      check("reset_addr_async", regAddress, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      repeat (5) @(negedge clk);
      check("idle_after_reset", tx, 1);

      // sweep 4: fresh sweep after reset restarts at register 0
      rx_en = 1'b1;
      base = rx_bytes;
      d0 = done_cnt;
      push_sweep();
      pulse_start();
      wait_done(d0, "sweep4_done");
      check("sweep4_bytes", rx_bytes - base, 32 * BPR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
